// File: rtl/deck_rom_arbiter_pkg.sv
// Shared constants and requester identifiers for the deck image ROM arbiter.
package deck_rom_pkg;

    localparam int ROM_ADDR_WIDTH = 13;
    localparam int ROM_DATA_WIDTH = 12;
    localparam int N_DECK_REQ     = 3;

    typedef enum logic [1:0] {
        REQ_PLAYER = 2'd0,
        REQ_DEALER = 2'd1,
        REQ_DECK   = 2'd2
    } req_id_t;

endpackage

// File: rtl/deck_rom_arbiter_if.sv
// Requester-side bus of the deck ROM arbiter: level requests, lock, addresses, grants, return data.
interface deck_rom_arbiter_if
    import deck_rom_pkg::*;
#(
    parameter int N_REQ      = N_DECK_REQ,
    parameter int ADDR_WIDTH = ROM_ADDR_WIDTH,
    parameter int DATA_WIDTH = ROM_DATA_WIDTH
);
    logic [N_REQ-1:0]            req;
    logic [N_REQ-1:0]            lock;
    logic [N_REQ*ADDR_WIDTH-1:0] addr;
    logic [N_REQ-1:0]            gnt;
    logic [N_REQ-1:0]            rvalid;
    logic [DATA_WIDTH-1:0]       rdata;

    modport master (
        output req, lock, addr,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, lock, addr,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/deck_rom_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning from i_start upward, wrapping.
module rr_pick
    import deck_rom_pkg::*;
#(
    parameter int N  = N_DECK_REQ,
    parameter int PW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_start,
    output logic [N-1:0]  o_gnt,
    output logic [PW-1:0] o_idx,
    output logic          o_any
);
    logic [PW-1:0] w_j;

    // Scan in reverse so the candidate closest to i_start is written last and wins.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_j   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_j = PW'((int'(i_start) + k) % N);
            if (i_req[w_j]) begin
                o_gnt      = '0;
                o_gnt[w_j] = 1'b1;
                o_idx      = w_j;
                o_any      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/deck_rom_arbiter.sv
// Shares the single-port deck ROM between draw units: round-robin grant with capped locked bursts.
module deck_rom_arbiter
    import deck_rom_pkg::*;
#(
    parameter int N_REQ      = N_DECK_REQ,
    parameter int ADDR_WIDTH = ROM_ADDR_WIDTH,
    parameter int DATA_WIDTH = ROM_DATA_WIDTH,
    parameter int MAX_BURST  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    deck_rom_arbiter_if.slave     bus,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_dout
);
    localparam int PW = $clog2(N_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

    logic [PW-1:0]         r_rr_ptr;
    logic [PW-1:0]         r_owner;
    logic                  r_owner_vld;
    logic [BW-1:0]         r_burst_cnt;
    logic [N_REQ-1:0]      r_rvalid;

    logic [N_REQ-1:0]      w_rr_gnt;
    logic [PW-1:0]         w_rr_idx;
    logic                  w_rr_any;
    logic                  w_hold;
    logic [N_REQ-1:0]      w_gnt;
    logic [PW-1:0]         w_idx;
    logic                  w_any;
    logic [ADDR_WIDTH-1:0] w_addr_sel [N_REQ];

    rr_pick #(
        .N  (N_REQ),
        .PW (PW)
    ) u_rr_pick (
        .i_req   (bus.req),
        .i_start (r_rr_ptr),
        .o_gnt   (w_rr_gnt),
        .o_idx   (w_rr_idx),
        .o_any   (w_rr_any)
    );

    // A locked owner keeps the port until it releases or has used up its burst.
    assign w_hold = r_owner_vld && bus.req[r_owner] && bus.lock[r_owner]
                    && (r_burst_cnt < BURST_MAX);

    always_comb begin
        w_gnt = w_rr_gnt;
        w_idx = w_rr_idx;
        w_any = w_rr_any;
        if (w_hold) begin
            w_gnt          = '0;
            w_gnt[r_owner] = 1'b1;
            w_idx          = r_owner;
            w_any          = 1'b1;
        end
        if (rst) begin
            w_gnt = '0;
            w_any = 1'b0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_addr_sel
            assign w_addr_sel[gi] = w_gnt[gi] ? bus.addr[gi*ADDR_WIDTH +: ADDR_WIDTH] : '0;
        end
    endgenerate

    always_comb begin
        rom_addr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rom_addr = rom_addr | w_addr_sel[i];
        end
    end

    assign bus.gnt    = w_gnt;
    assign bus.rvalid = rst ? '0 : r_rvalid;
    assign bus.rdata  = rom_dout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_owner_vld <= 1'b0;
            r_burst_cnt <= '0;
            r_rvalid    <= '0;
        end else begin
            r_rvalid <= w_gnt;
            if (w_any) begin
                r_rr_ptr <= (w_idx == PW'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
                if (bus.lock[w_idx]) begin
                    r_owner_vld <= 1'b1;
                    r_owner     <= w_idx;
                    // A capped owner regranted by round-robin starts a fresh burst.
                    r_burst_cnt <= (r_owner_vld && (r_owner == w_idx) && (r_burst_cnt < BURST_MAX))
                                   ? r_burst_cnt + 1'b1 : BW'(1);
                end else begin
                    r_owner_vld <= 1'b0;
                    r_burst_cnt <= '0;
                end
            end else begin
                r_owner_vld <= 1'b0;
                r_burst_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_deck_rom_arbiter.sv
// Randomised and directed bench for deck_rom_arbiter against a behavioural arbitration model.
module tb_deck_rom_arbiter;
    import deck_rom_pkg::*;

    localparam int N  = 3;
    localparam int AW = 13;
    localparam int DW = 12;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    deck_rom_arbiter_if #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_dout;

    deck_rom_arbiter #(
        .N_REQ      (N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .rom_addr (rom_addr),
        .rom_dout (rom_dout)
    );

    logic [DW-1:0] rom [0:(1<<AW)-1];
    always @(posedge clk) rom_dout <= rom[rom_addr];

    int checks = 0;
    int errors = 0;

    // Model state, following the arbitration rules directly.
    int            m_ptr   = 0;
    int            m_owner = -1;
    int            m_burst = 0;
    int            prev_g  = -1;
    logic [AW-1:0] prev_addr = '0;
    int            g_log[$];
    int            b_log[$];
    int            cyc_n = 0;
    int            g;
    logic [N-1:0]  eg;
    logic [N-1:0]  ev;
    logic [AW-1:0] ga;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc_n, act, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] rq, input logic [N-1:0] lk);
        if (m_owner >= 0 && rq[m_owner] && lk[m_owner] && m_burst < MB) return m_owner;
        for (int k = 0; k < N; k++) begin
            if (rq[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        cyc_n++;
        if (rst) begin
            chk("rst_gnt", 64'(bus.gnt), 64'd0);
            chk("rst_rom_addr", 64'(rom_addr), 64'd0);
            chk("rst_rvalid", 64'(bus.rvalid), 64'd0);
            m_ptr   = 0;
            m_owner = -1;
            m_burst = 0;
            prev_g  = -1;
        end else begin
            g  = pick(bus.req, bus.lock);
            eg = '0;
            ga = '0;
            if (g >= 0) begin
                eg[g] = 1'b1;
                ga    = bus.addr[g*AW +: AW];
            end
            ev = '0;
            if (prev_g >= 0) ev[prev_g] = 1'b1;
            chk("gnt", 64'(bus.gnt), 64'(eg));
            chk("rom_addr", 64'(rom_addr), 64'(ga));
            chk("rvalid", 64'(bus.rvalid), 64'(ev));
            if (prev_g >= 0) begin
                chk("rdata", 64'(bus.rdata), 64'(rom[prev_addr]));
                $display("txn cyc=%0d req=%0d addr=%h rdata=%h", cyc_n, prev_g, prev_addr, bus.rdata);
            end
            if (g >= 0) begin
                m_ptr = (g + 1) % N;
                if (bus.lock[g]) begin
                    m_burst = (m_owner == g && m_burst < MB) ? m_burst + 1 : 1;
                    m_owner = g;
                end else begin
                    m_owner = -1;
                    m_burst = 0;
                end
            end else begin
                m_owner = -1;
                m_burst = 0;
            end
            g_log.push_back(g);
            b_log.push_back(m_burst);
            prev_g    = g;
            prev_addr = ga;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int s;
    int exp2 [6];

    initial begin
        for (int i = 0; i < (1 << AW); i++) rom[i] = DW'($urandom);
        rom[13'h0A5] = 12'hF0F;
        bus.req  = '0;
        bus.lock = '0;
        bus.addr = '0;
        rst      = 1'b1;
        repeat (3) step();

        // Single request
        rst = 1'b0;
        bus.addr[0 +: AW] = 13'h0A5;
        bus.req = 3'b001;
        s = g_log.size();
        step();
        chk("t1_model_gnt", 64'(g_log[s]), 64'd0);
        chk("t1_rvalid", 64'(bus.rvalid), 64'h1);
        chk("t1_rdata", 64'(bus.rdata), 64'hF0F);
        bus.req = '0;
        step();

        // All requesting, no lock
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.req  = 3'b111;
        bus.lock = 3'b000;
        bus.addr = {AW'($urandom), AW'($urandom), AW'($urandom)};
        s = g_log.size();
        repeat (6) step();
        exp2 = '{0, 1, 2, 0, 1, 2};
        for (int k = 0; k < 6; k++) chk("t2_model_seq", 64'(g_log[s+k]), 64'(exp2[k]));

        // Locked requester 0 competing with requester 1
        rst = 1'b1;
        bus.req = '0;
        step();
        rst = 1'b0;
        bus.req  = 3'b011;
        bus.lock = 3'b001;
        s = g_log.size();
        repeat (15) step();
        for (int k = 0; k < 15; k++) chk("t3_model_seq", 64'(g_log[s+k]), (k % 5 == 4) ? 64'd1 : 64'd0);

        // Lone locked requester: no gaps at the cap
        rst = 1'b1;
        bus.req = '0;
        step();
        rst = 1'b0;
        bus.req  = 3'b001;
        bus.lock = 3'b001;
        s = g_log.size();
        repeat (10) step();
        for (int k = 0; k < 10; k++) begin
            chk("t4_model_gnt", 64'(g_log[s+k]), 64'd0);
            chk("t4_model_burst", 64'(b_log[s+k]), 64'((k % 4) + 1));
        end

        // Back-to-back addresses from requester 2
        bus.req  = 3'b100;
        bus.lock = 3'b000;
        s = g_log.size();
        bus.addr[2*AW +: AW] = 13'h0000;
        step();
        bus.addr[2*AW +: AW] = 13'h0001;
        step();
        bus.addr[2*AW +: AW] = 13'h1FFF;
        step();
        bus.req = '0;
        step();
        for (int k = 0; k < 3; k++) chk("t5_model_gnt", 64'(g_log[s+k]), 64'd2);

        // Reset right after a grant to requester 1
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.req = 3'b010;
        step();
        rst = 1'b1;
        bus.req = '0;
        #1;
        chk("t6_rvalid_in_rst", 64'(bus.rvalid), 64'd0);
        step();
        rst = 1'b0;
        bus.req = 3'b110;
        s = g_log.size();
        #1;
        chk("t6_rvalid_after_rst", 64'(bus.rvalid), 64'd0);
        step();
        chk("t6_model_first", 64'(g_log[s]), 64'd1);
        chk("t6_rvalid_first", 64'(bus.rvalid), 64'h2);

        // Randomised traffic
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 3) == 0) bus.req = N'($urandom);
            if ($urandom_range(0, 3) == 0) bus.lock = N'($urandom);
            else if ($urandom_range(0, 7) == 0) bus.lock = bus.req;
            bus.addr = {AW'($urandom), AW'($urandom), AW'($urandom)};
            step();
        end
        rst = 1'b0;
        bus.req = '0;
        repeat (2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
